// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access / write-back stage of the 16-bit MIPS pipeline.
//            Performs word loads and stores against an internal synchronous
//            data memory and emits one registered write-back transaction per
//            accepted operation. Out-of-range and illegal (load+store)
//            operations are flagged as faults and suppress all side effects.
// Config   : DM_INIT_CLEAR_EN - when defined, the memory is zero-filled one
//            word per cycle after every reset (CLEAR state) before the stage
//            becomes ready. When undefined, the stage is ready immediately
//            and memory contents after reset are unspecified.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous, active-low reset
//            valid_in    - operation presented this cycle
//            ans_ex      - ALU result / effective word address
//            DM_data     - store data
//            flag_ex     - ALU flags from execute
//            mem_rd      - load operation
//            mem_wr      - store operation
//            wb_en       - operation writes a register
//            wb_addr     - destination register
//            ready       - stage accepts an operation this cycle
//            wb_data     - write-back data
//            wb_addr_out - write-back register
//            wb_we       - register-file write strobe (one cycle)
//            flag_mem    - flags of the last accepted operation
//            mem_fault   - last accepted operation faulted (one cycle)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RF_AW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [15:0]      ans_ex,
  input  logic [15:0]      DM_data,
  input  logic [1:0]       flag_ex,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             wb_en,
  input  logic [RF_AW-1:0] wb_addr,
  output logic             ready,
  output logic [15:0]      wb_data,
  output logic [RF_AW-1:0] wb_addr_out,
  output logic             wb_we,
  output logic [1:0]       flag_mem,
  output logic             mem_fault
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_READY = 1'b1;
`ifdef DM_INIT_CLEAR_EN
  localparam logic [0:0]        S_CLEAR     = 1'b0;
  localparam logic [0:0]        RESET_STATE = S_CLEAR;
  localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(DEPTH - 1);
`else
  localparam logic [0:0]        RESET_STATE = S_READY;
`endif

  logic [0:0] state_q;
  logic [0:0] state_d;

`ifdef DM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic              clr_we;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
`ifdef DM_INIT_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef DM_INIT_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
`ifdef DM_INIT_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        // One word cleared per cycle; leave after the last word is written.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase
`else
    state_d = S_READY;
`endif
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // ready is gated by reset so that nothing is accepted while reset is held,
  // even though the state register already sits in its reset state.
  // --------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
`ifdef DM_INIT_CLEAR_EN
    clr_we = 1'b0;
`endif
    case (state_q)
      S_READY: ready = reset;
`ifdef DM_INIT_CLEAR_EN
      S_CLEAR: clr_we = reset;
`endif
      default: ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operation decode
  // --------------------------------------------------------------------------
  logic              accept;
  logic              addr_hi_nz;
  logic              fault;
  logic [ADDR_W-1:0] addr;

  assign accept     = valid_in && ready;
  assign addr       = ans_ex[ADDR_W-1:0];
  // Any bit above the word-address field makes a memory access out of range;
  // there is deliberately no wrap-around.
  assign addr_hi_nz = (ans_ex >> ADDR_W) != 16'd0;
  assign fault      = ((mem_rd || mem_wr) && addr_hi_nz) || (mem_rd && mem_wr);

  // --------------------------------------------------------------------------
  // Data memory write port (shared between stores and the clear sweep)
  // --------------------------------------------------------------------------
  logic [15:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  always_comb begin
    mem_we    = accept && mem_wr && !fault;
    mem_waddr = addr;
    mem_wdata = DM_data;
`ifdef DM_INIT_CLEAR_EN
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = 16'd0;
    end
`endif
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back registers
  // The load reads mem[] with the pre-edge value; a store committed at the
  // same edge becomes visible to a load accepted one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_data     <= 16'd0;
      wb_addr_out <= '0;
      wb_we       <= 1'b0;
      flag_mem    <= 2'b00;
      mem_fault   <= 1'b0;
    end else if (accept) begin
      wb_addr_out <= wb_addr;
      flag_mem    <= flag_ex;
      mem_fault   <= fault;
      wb_we       <= wb_en && !fault;
      if (fault) begin
        wb_data <= 16'd0;
      end else if (mem_rd) begin
        wb_data <= mem[addr];
      end else begin
        // Non-memory ops and stores forward the ALU result.
        wb_data <= ans_ex;
      end
    end else begin
      wb_we     <= 1'b0;
      mem_fault <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Directed scenarios
//            followed by randomized operations, each compared against a
//            behavioural memory/write-back model. Honors DM_INIT_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int RF_AW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [15:0]      ans_ex;
  logic [15:0]      DM_data;
  logic [1:0]       flag_ex;
  logic             mem_rd;
  logic             mem_wr;
  logic             wb_en;
  logic [RF_AW-1:0] wb_addr;
  logic             ready;
  logic [15:0]      wb_data;
  logic [RF_AW-1:0] wb_addr_out;
  logic             wb_we;
  logic [1:0]       flag_mem;
  logic             mem_fault;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .RF_AW (RF_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ans_ex     (ans_ex),
    .DM_data    (DM_data),
    .flag_ex    (flag_ex),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .ready      (ready),
    .wb_data    (wb_data),
    .wb_addr_out(wb_addr_out),
    .wb_we      (wb_we),
    .flag_mem   (flag_mem),
    .mem_fault  (mem_fault)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0]      m_mem [DEPTH];
  logic [15:0]      e_data;
  logic [RF_AW-1:0] e_addr;
  logic             e_we;
  logic [1:0]       e_flag;
  logic             e_fault;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".wb_we"},       16'(wb_we),       16'(e_we));
    chk({tag, ".mem_fault"},   16'(mem_fault),   16'(e_fault));
    chk({tag, ".wb_data"},     wb_data,          e_data);
    chk({tag, ".wb_addr_out"}, 16'(wb_addr_out), 16'(e_addr));
    chk({tag, ".flag_mem"},    16'(flag_mem),    16'(e_flag));
  endtask

  // Model of one accepted operation, written from the operation rules.
  task automatic model_op(input logic [15:0] a, input logic [15:0] d, input logic [1:0] f,
                          input logic rd, input logic wr, input logic we,
                          input logic [RF_AW-1:0] wa);
    logic flt;
    int   idx;
    idx     = int'(a) % DEPTH;
    flt     = ((rd || wr) && int'(a) >= DEPTH) || (rd && wr);
    e_addr  = wa;
    e_flag  = f;
    e_fault = flt;
    e_we    = we && !flt;
    if (flt)     e_data = 16'h0000;
    else if (rd) e_data = m_mem[idx];
    else         e_data = a;
    if (wr && !flt) m_mem[idx] = d;
  endtask

  // Present one operation (stage must be ready) and check the result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] f, input logic rd, input logic wr,
                       input logic we, input logic [RF_AW-1:0] wa);
    chk({tag, ".ready"}, 16'(ready), 16'h0001);
    valid_in = 1'b1; ans_ex = a; DM_data = d; flag_ex = f;
    mem_rd = rd; mem_wr = wr; wb_en = we; wb_addr = wa;
    model_op(a, d, f, rd, wr, we, wa);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_outs(tag);
  endtask

  // Idle cycle with junk on the data inputs: strobes drop, data holds.
  task automatic do_idle(input string tag);
    valid_in = 1'b0; ans_ex = 16'($urandom); DM_data = 16'($urandom);
    flag_ex = 2'($urandom); mem_rd = 1'b1; mem_wr = 1'b1; wb_en = 1'b1;
    wb_addr = RF_AW'($urandom);
    e_we = 1'b0; e_fault = 1'b0;
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  // Reset with a live operation presented, then release and wait for ready.
  task automatic do_reset(input string tag);
    int cyc;
    reset = 1'b0; valid_in = 1'b1; ans_ex = 16'h0001; DM_data = 16'hDEAD;
    mem_rd = 1'b0; mem_wr = 1'b1; wb_en = 1'b1; wb_addr = 3'd7; flag_ex = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e_data = 16'h0; e_addr = '0; e_we = 1'b0; e_flag = 2'b00; e_fault = 1'b0;
    check_outs({tag, ".rst"});
    chk({tag, ".rst.ready"}, 16'(ready), 16'h0000);
    reset = 1'b1;
`ifdef DM_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 4 * DEPTH) begin
      valid_in = 1'b1; ans_ex = 16'($urandom_range(0, DEPTH - 1));
      mem_wr = 1'b1; mem_rd = 1'b0; wb_en = 1'b1;
      @(posedge clk); #1;
      cyc++;
      chk({tag, ".clr.wb_we"},     16'(wb_we),     16'h0000);
      chk({tag, ".clr.mem_fault"}, 16'(mem_fault), 16'h0000);
    end
    valid_in = 1'b0;
    chk({tag, ".clr.cycles"}, 16'(cyc), 16'(DEPTH));
`else
    cyc = 0;
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rel.ready"}, 16'(ready), 16'h0001);
    check_outs({tag, ".rel"});
`endif
  endtask

  initial begin
    logic [15:0] a;
    logic        rd, wr;
    int          k;
    reset = 1'b1; valid_in = 1'b0; ans_ex = '0; DM_data = '0; flag_ex = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; wb_en = 1'b0; wb_addr = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;

    @(posedge clk); #1;
    do_reset("reset");

`ifdef DM_INIT_CLEAR_EN
    do_op("clr_ff", 16'h00FF, 16'h0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd1);
    chk("clr_ff.zero", wb_data, 16'h0000);
`else
    // Memory is unspecified after reset: give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      valid_in = 1'b1; ans_ex = 16'(i); DM_data = 16'($urandom);
      flag_ex = 2'b00; mem_rd = 1'b0; mem_wr = 1'b1; wb_en = 1'b0; wb_addr = '0;
      model_op(ans_ex, DM_data, 2'b00, 1'b0, 1'b1, 1'b0, '0);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check_outs("fill");
`endif

    // Store then load, back to back
    do_op("st10", 16'h0010, 16'hC000, 2'b01, 1'b0, 1'b1, 1'b0, 3'd0);
    do_op("ld10", 16'h0010, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 3'd3);
    chk("ld10.data", wb_data, 16'hC000);
    // Non-memory op
    do_op("alu", 16'h0008, 16'h1111, 2'b10, 1'b0, 1'b0, 1'b1, 3'd5);
    chk("alu.data", wb_data, 16'h0008);
    do_idle("hold1");
    // Out of range
    do_op("oor_st", 16'h4000, 16'h1234, 2'b00, 1'b0, 1'b1, 1'b0, 3'd2);
    do_op("oor_ld", 16'h4000, 16'h0000, 2'b01, 1'b1, 1'b0, 1'b1, 3'd2);
    chk("oor_ld.fault", 16'(mem_fault), 16'h0001);
    do_op("ld00", 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 3'd4);
    // Boundaries
    do_op("ldff",  16'h00FF, 16'h0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd6);
    do_op("ld100", 16'h0100, 16'h0, 2'b11, 1'b1, 1'b0, 1'b1, 3'd6);
    chk("ld100.fault", 16'(mem_fault), 16'h0001);
    // Illegal load+store must not write
    do_op("st20",  16'h0020, 16'h5A5A, 2'b00, 1'b0, 1'b1, 1'b1, 3'd1);
    do_op("ill20", 16'h0020, 16'hBEEF, 2'b10, 1'b1, 1'b1, 1'b1, 3'd1);
    do_op("ld20",  16'h0020, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 3'd1);
    chk("ld20.data", wb_data, 16'h5A5A);
    do_idle("hold2");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_idle("rnd_idle");
      end else begin
        k = $urandom_range(0, 9);
        if (k < 7)       a = 16'($urandom_range(0, DEPTH - 1));
        else if (k == 7) a = 16'(DEPTH);
        else if (k == 8) a = 16'(DEPTH - 1);
        else             a = 16'($urandom);
        k = $urandom_range(0, 9);
        rd = (k <= 3) || (k == 9);
        wr = (k >= 4 && k <= 6) || (k == 9);
        do_op("rnd", a, 16'($urandom), 2'($urandom), rd, wr, 1'($urandom),
              RF_AW'($urandom));
      end
    end

    // Reset in the middle of traffic; memory survives unless cleared.
    do_op("pre_rst", 16'h0033, 16'h7777, 2'b01, 1'b0, 1'b1, 1'b1, 3'd2);
    do_reset("midrst");
    do_op("post_ld33", 16'h0033, 16'h0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd2);
    for (int n = 0; n < 20; n++) begin
      do_op("post_ld", 16'($urandom_range(0, DEPTH - 1)), 16'h0, 2'($urandom),
            1'b1, 1'b0, 1'b1, RF_AW'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access/write-back stage of the 16-bit MIPS pipeline, directly downstream of `execution_block`. It consumes `ans_ex`, `DM_data` and `flag_ex` and performs word loads and stores against an internal synchronous data memory. It produces one registered write-back transaction (data, destination register, enable) per accepted operation. It also flags out-of-range memory accesses.

## Interface
- `ADDR_W`, 8: data-memory word-address width.
- `DEPTH`, 256: number of data-memory words; must equal 2^`ADDR_W`.
- `RF_AW`, 3: register-file address width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  an operation is presented this cycle.
- `ans_ex`  in  16  ALU result or effective word address.
- `DM_data`  in  16  store data.
- `flag_ex`  in  2  ALU flags from execute.
- `mem_rd`  in  1  load operation.
- `mem_wr`  in  1  store operation.
- `wb_en`  in  1  operation writes a register.
- `wb_addr`  in  `RF_AW`  destination register.
- `ready`  out  1  stage accepts an operation this cycle.
- `wb_data`  out  16  write-back data.
- `wb_addr_out`  out  `RF_AW`  write-back register.
- `wb_we`  out  1  register-file write strobe, one cycle wide.
- `flag_mem`  out  2  flags of the last accepted operation.
- `mem_fault`  out  1  the last accepted memory operation faulted; one cycle wide.

## Operation
- **Accept condition:** `valid_in && ready` at a rising edge. When `ready` = 0, inputs are ignored; upstream must hold them.
- **Address:** `addr = ans_ex[ADDR_W-1:0]`.
- **Out of range:** `ans_ex[15:ADDR_W] != 0` with `mem_rd` or `mem_wr` set.
- **Illegal:** `mem_rd && mem_wr` both set.
- **Fault:** an out-of-range or illegal operation.

Per accepted operation:
- **Store** (`mem_wr`, no fault): `mem[addr] <= DM_data`.
- **Load** (`mem_rd`, no fault): `wb_data <= mem[addr]` (synchronous read).
- **Non-memory op** (neither set): `wb_data <= ans_ex`.
- **On fault:**
  - No memory write.
  - `wb_data <= 0`, `wb_we <= 0`, `mem_fault <= 1`.
- **Write strobe:** `wb_we <= wb_en && !fault`. A store with `wb_en` = 1 writes `ans_ex` back.
- **Write-back register:** `wb_addr_out <= wb_addr`.
- **Flags:** `flag_mem <= flag_ex` on every accepted operation; held otherwise.
- **No accept:**
  - `wb_we <= 0` and `mem_fault <= 0`.
  - `wb_data`, `wb_addr_out` and `flag_mem` hold.

State machine: `CLEAR` and `READY`.
- `ready` = 1 only in `READY`.
- `CLEAR` exists only when the configuration macro is defined (see Configuration).

## Timing
- **Reset values** (while `reset` = 0 at an edge):
  - `wb_data` = 0, `wb_addr_out` = 0, `wb_we` = 0, `flag_mem` = 0, `mem_fault` = 0.
  - `ready` = 0.
  - FSM goes to `CLEAR`, or to `READY` when clearing is compiled out.
  - Clear counter = 0.
- **Latency:** an operation accepted at edge N drives `wb_*`, `flag_mem` and `mem_fault` after edge N, valid for exactly one cycle.
- **Store to memory:** the store commits at edge N. A load of the same address accepted at edge N+1 returns the new value. No bypass logic is required.
- **Back-to-back:** one operation per cycle with no bubbles while `ready` = 1.
- **Reset mid-operation:** discards pending outputs. Memory contents are preserved unless clearing is compiled in.
- **Address boundaries:** `ans_ex` = `DEPTH`-1 is valid; `ans_ex` = `DEPTH` faults. There is no wrap-around.

## Configuration
- **`DM_INIT_CLEAR_EN` defined:**
  - After reset deasserts, the FSM stays in `CLEAR` for exactly `DEPTH` cycles.
  - A counter writes 0 to `mem[0]` .. `mem[DEPTH-1]`, one word per cycle, then enters `READY`.
  - `ready` is first 1 on the cycle after the write to `mem[DEPTH-1]`.
  - Reset asserted during `CLEAR` restarts the counter from 0.
- **`DM_INIT_CLEAR_EN` undefined:**
  - No `CLEAR` state and no counter.
  - `ready` = 1 from the first edge with `reset` = 1.
  - Memory contents after reset are unspecified.

## Test plan
- **Reset/clear:** hold `reset` = 0 for 2 cycles, then release.
  - With the macro: `ready` = 0 for 256 cycles, then 1; a load of addr 0x00FF returns 0x0000.
  - Without the macro: `ready` = 1 on the first cycle after release.
- **Store then load:** store `ans_ex`=0x0010, `DM_data`=0xC000; next cycle load `ans_ex`=0x0010 with `wb_en`=1, `wb_addr`=3.
  - Next cycle: `wb_data`=0xC000, `wb_addr_out`=3, `wb_we`=1.
- **Non-memory op:** `ans_ex`=0x0008, `flag_ex`=2'b10, `wb_en`=1, `wb_addr`=5.
  - Next cycle: `wb_data`=0x0008, `wb_addr_out`=5, `wb_we`=1, `flag_mem`=2'b10.
- **Out-of-range:** store `ans_ex`=0x4000, `DM_data`=0x1234, then load 0x4000 with `wb_en`=1.
  - `mem_fault`=1 for each operation; `wb_we`=0 and `wb_data`=0 for the load.
  - `mem[0x00]` is unchanged.
- **Boundary:** load 0x00FF → no fault; load 0x0100 → `mem_fault`=1.
- **Illegal/stall:** `mem_rd`=`mem_wr`=1 → `mem_fault`=1 and no memory write.
  - During `CLEAR`, `valid_in`=1 → no `wb_we`, no fault.
